// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues imem reads and latches IF/ID for decode.
// Latency: an imem hit at PC=A in cycle N is visible in IF/ID from cycle N+1; 1 instr/cycle sustained.
// Backpressure: stall holds PC and IF/ID (the in-flight word is refetched), flush/redirect insert bubbles.
module fetch_stage #(
    parameter logic [31:0] PC_INIT  = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_addr,
    input  logic        halt_ID,
    output logic [31:0] instr_ID,
    output logic [31:0] imemaddr_ID,
    output logic [31:0] next_addr_ID,
    output logic        valid_ID,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_REDIR = 2'd1,
        ST_HALTED     = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        vld;
    } ifid_t;

    localparam logic [31:0] PC_RST = PC_INIT & 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    ifid_t       ifid_q, ifid_d;
    logic [31:0] cnt_q, cnt_d;
    logic        imem_ren_q, imem_ren_d;

    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        bubble;

    assign pc_plus4  = pc_q + 32'd4;
    assign redir_tgt = redirect_addr & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ifid_d  = ifid_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (redirect_en) begin
                    // Redirect beats a same-cycle HALT: that HALT is on the wrong path.
                    bubble = 1'b1;
                    if (ihit) begin
                        pc_d = redir_tgt;
                    end else begin
                        tgt_d   = redir_tgt;
                        state_d = ST_WAIT_REDIR;
                    end
                end else if (halt_ID && !stall) begin
                    bubble  = 1'b1;
                    state_d = ST_HALTED;
                end else if (stall) begin
                    bubble = flush;
                end else if (flush) begin
                    bubble = 1'b1;
                end else if (ihit) begin
                    ifid_d.instr = imemload;
                    ifid_d.pc    = pc_q;
                    ifid_d.npc   = pc_plus4;
                    ifid_d.vld   = 1'b1;
                    pc_d         = pc_plus4;
                    cnt_d        = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
                end
            end

            ST_WAIT_REDIR: begin
                // The old request must complete before the PC may move; its data is dropped.
                if (redirect_en) begin
                    tgt_d = redir_tgt;
                end
                if (ihit) begin
                    pc_d    = redirect_en ? redir_tgt : tgt_q;
                    state_d = ST_RUN;
                end
            end

            ST_HALTED: begin
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (bubble) begin
            ifid_d.instr = NOP_WORD;
            ifid_d.vld   = 1'b0;
        end

        imem_ren_d = (state_d != ST_HALTED);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RUN;
            pc_q       <= PC_RST;
            tgt_q      <= 32'h0000_0000;
            ifid_q     <= '{instr: NOP_WORD, pc: 32'h0, npc: 32'h0, vld: 1'b0};
            cnt_q      <= 32'h0000_0000;
            imem_ren_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            ifid_q     <= ifid_d;
            cnt_q      <= cnt_d;
            imem_ren_q <= imem_ren_d;
        end
    end

    assign imemaddr     = pc_q;
    assign imemREN      = imem_ren_q;
    assign instr_ID     = ifid_q.instr;
    assign imemaddr_ID  = ifid_q.pc;
    assign next_addr_ID = ifid_q.npc;
    assign valid_ID     = ifid_q.vld;
    assign fetch_cnt    = cnt_q;

endmodule
